// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer between MEM and CP0: prioritizes exceptions, flushes, then redirects fetch.
// Optional macro EXC_CTRL_TRAP_EN enables the TRAP flag (mem_exc_i[4], code 0x0d).
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR      = 32'hBFC00380,
  parameter int unsigned FLUSH_CYCLES    = 2,
  parameter int unsigned INT_SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  ext_int_i,
  input  logic        timer_int_i,
  output logic [5:0]  int_o,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_delayslot_i,
  input  logic [8:0]  mem_exc_i,
  input  logic [31:0] mem_data_addr_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] exc_pc_o,
  output logic        exc_delayslot_o,
  output logic [31:0] bad_addr_o,
  output logic        flush_o,
  output logic        busy_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  input  logic        redirect_ready_i,
  output logic [1:0]  dbg_state_o
);

  // Handshake: redirect_pc_o is held stable while redirect_valid_o=1; the transfer
  // happens on the edge where redirect_valid_o=1 and redirect_ready_i=1 are both sampled.
  typedef enum logic [1:0] {IDLE = 2'd0, FLUSH = 2'd1, REDIRECT = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] excepttype_q, excepttype_d;
  logic [31:0] exc_pc_q, exc_pc_d;
  logic        exc_ds_q, exc_ds_d;
  logic [31:0] bad_addr_q, bad_addr_d;
  logic        flush_q, flush_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rpc_q, rpc_d;
  logic [5:0]  sync_q [INT_SYNC_STAGES];

  logic        int_pending;
  logic [7:0]  exc_code;
  logic        is_eret, fetch_ade, data_ade;
  logic        unused_ok;

  assign unused_ok = ^{cp0_status_i[31:16], cp0_status_i[7:2], cp0_cause_i[31:16], cp0_cause_i[7:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(INT_SYNC_STAGES); i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= ext_int_i;
      for (int i = 1; i < int'(INT_SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign int_o = {sync_q[INT_SYNC_STAGES-1][5] | timer_int_i, sync_q[INT_SYNC_STAGES-1][4:0]};

  assign int_pending = cp0_status_i[0] & ~cp0_status_i[1] &
                       (|(cp0_cause_i[15:8] & cp0_status_i[15:8]));

  // Priority encoder: interrupt first, ERET last.
  always_comb begin
    exc_code  = 8'h00;
    is_eret   = 1'b0;
    fetch_ade = 1'b0;
    data_ade  = 1'b0;
    if (int_pending)       exc_code = 8'h01;
    else if (mem_exc_i[0]) begin exc_code = 8'h04; fetch_ade = 1'b1; end
    else if (mem_exc_i[1]) exc_code = 8'h0a;
    else if (mem_exc_i[2]) exc_code = 8'h08;
    else if (mem_exc_i[3]) exc_code = 8'h09;
`ifdef EXC_CTRL_TRAP_EN
    else if (mem_exc_i[4]) exc_code = 8'h0d;
`endif
    else if (mem_exc_i[5]) exc_code = 8'h0c;
    else if (mem_exc_i[6]) begin exc_code = 8'h04; data_ade = 1'b1; end
    else if (mem_exc_i[7]) begin exc_code = 8'h05; data_ade = 1'b1; end
    else if (mem_exc_i[8]) begin exc_code = 8'h0e; is_eret = 1'b1; end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    excepttype_d = '0;
    exc_pc_d     = exc_pc_q;
    exc_ds_d     = exc_ds_q;
    bad_addr_d   = bad_addr_q;
    flush_d      = flush_q;
    rvalid_d     = rvalid_q;
    rpc_d        = rpc_q;
    case (state_q)
      IDLE: begin
        if (mem_valid_i && (exc_code != 8'h00)) begin
          excepttype_d = {24'h0, exc_code};
          exc_pc_d     = mem_pc_i;
          exc_ds_d     = mem_in_delayslot_i;
          if (fetch_ade)     bad_addr_d = mem_pc_i;
          else if (data_ade) bad_addr_d = mem_data_addr_i;
          rpc_d   = is_eret ? cp0_epc_i : EXC_VECTOR;
          flush_d = 1'b1;
          cnt_d   = FLUSH_CYCLES[3:0];
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          flush_d  = 1'b0;
          rvalid_d = 1'b1;
          state_d  = REDIRECT;
        end
      end
      REDIRECT: begin
        if (redirect_ready_i) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      excepttype_q <= '0;
      exc_pc_q     <= '0;
      exc_ds_q     <= 1'b0;
      bad_addr_q   <= '0;
      flush_q      <= 1'b0;
      rvalid_q     <= 1'b0;
      rpc_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      excepttype_q <= excepttype_d;
      exc_pc_q     <= exc_pc_d;
      exc_ds_q     <= exc_ds_d;
      bad_addr_q   <= bad_addr_d;
      flush_q      <= flush_d;
      rvalid_q     <= rvalid_d;
      rpc_q        <= rpc_d;
    end
  end

  assign excepttype_o     = excepttype_q;
  assign exc_pc_o         = exc_pc_q;
  assign exc_delayslot_o  = exc_ds_q;
  assign bad_addr_o       = bad_addr_q;
  assign flush_o          = flush_q;
  assign busy_o           = (state_q != IDLE);
  assign redirect_valid_o = rvalid_q;
  assign redirect_pc_o    = rpc_q;
  assign dbg_state_o      = state_q;

endmodule
